// File: rtl/coco_uart_tx.sv
// coco_uart_tx: memory-mapped 8N1 UART transmitter.
// It has a small transmit FIFO, a programmable bit period and a frame-done interrupt.
module coco_uart_tx #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:2]  DevAddr,
   input  logic        WE,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        Irq,
   output logic        txd
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;

   localparam logic [1:0] AddrCtrl   = 2'd0;
   localparam logic [1:0] AddrBaud   = 2'd1;
   localparam logic [1:0] AddrTxData = 2'd2;
   localparam logic [1:0] AddrStatus = 2'd3;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   // Registers
   logic            en_q, im_q;
   logic [15:0]     baud_q;
   logic            pend_q, pend_d;
   logic            ovf_q, ovf_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;

   state_e          state_q, state_d;
   logic [15:0]     clk_cnt_q, clk_cnt_d;
   logic [15:0]     period_q, period_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;

   // Decode and FIFO status
   logic wr_ctrl, wr_baud, wr_txdata, wr_status;
   logic full, empty, push, pop, frame_done, bit_end;
   logic [15:0] baud_eff;
   logic unused_wd;

   assign wr_ctrl   = WE && (DevAddr == AddrCtrl);
   assign wr_baud   = WE && (DevAddr == AddrBaud);
   assign wr_txdata = WE && (DevAddr == AddrTxData);
   assign wr_status = WE && (DevAddr == AddrStatus);

   assign full      = (count_q == CntW'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign push      = wr_txdata && !full;
   assign baud_eff  = (baud_q == 16'd0) ? 16'd1 : baud_q;
   assign bit_end   = (clk_cnt_q == period_q - 16'd1);
   assign unused_wd = ^WD[31:16];

   // Control and divisor registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q   <= 1'b0;
         im_q   <= 1'b0;
         baud_q <= DIV_RESET;
      end else begin
         if (wr_ctrl) begin
            en_q <= WD[0];
            im_q <= WD[3];
         end
         if (wr_baud) begin
            baud_q <= WD[15:0];
         end
      end
   end

   // Sticky status flags; a set wins over a simultaneous write-1-to-clear
   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (wr_status && WD[5]) pend_d = 1'b0;
      if (wr_status && WD[6]) ovf_d  = 1'b0;
      if (frame_done && empty) pend_d = 1'b1;
      if (wr_txdata && full)   ovf_d  = 1'b1;
   end

   // Status flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
      end
   end

   // FIFO storage; contents need no reset since count guards every read
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= WD[7:0];
      end
   end

   // FIFO occupancy: a same-edge push and pop leaves the count unchanged
   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO pointers and count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_d;
      end
   end

   // Transmit FSM next state: frame start pops the head and latches the bit period
   always_comb begin
      state_d    = state_q;
      clk_cnt_d  = clk_cnt_q;
      period_d   = period_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      pop        = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         StIdle: begin
            if (en_q && !empty) begin
               pop       = 1'b1;
               state_d   = StStart;
               clk_cnt_d = 16'd0;
               period_d  = baud_eff;
               shift_d   = mem_q[rd_ptr_q];
            end
         end
         StStart: begin
            if (bit_end) begin
               state_d   = StData;
               clk_cnt_d = 16'd0;
               bit_cnt_d = 3'd0;
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end
         StData: begin
            if (bit_end) begin
               clk_cnt_d = 16'd0;
               shift_d   = shift_q >> 1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end
         StStop: begin
            if (bit_end) begin
               frame_done = 1'b1;
               clk_cnt_d  = 16'd0;
               // Back-to-back frames skip IDLE entirely
               if (en_q && !empty) begin
                  pop      = 1'b1;
                  state_d  = StStart;
                  period_d = baud_eff;
                  shift_d  = mem_q[rd_ptr_q];
               end else begin
                  state_d = StIdle;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Transmit FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         clk_cnt_q <= 16'd0;
         period_q  <= 16'd1;
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'd0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         period_q  <= period_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
      end
   end

   // Serial line decoded from registered state, so reset forces it high at once
   always_comb begin
      txd = 1'b1;
      case (state_q)
         StStart: txd = 1'b0;
         StData:  txd = shift_q[0];
         default: txd = 1'b1;
      endcase
   end

   assign Irq = pend_q & im_q;

   // Register read mux
   always_comb begin
      RD = 32'd0;
      case (DevAddr)
         AddrCtrl:   RD = {28'd0, im_q, 2'b00, en_q};
         AddrBaud:   RD = {16'd0, baud_q};
         AddrTxData: RD = 32'd0;
         AddrStatus: RD = {23'd0, empty, full, ovf_q, pend_q, (state_q != StIdle),
                           4'(count_q)};
         default:    RD = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_coco_uart_tx.sv
// Directed self-checking bench for coco_uart_tx.
module tb_coco_uart_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:2]  DevAddr = 2'd0;
   logic        WE = 1'b0;
   logic [31:0] WD = 32'd0;
   logic [31:0] RD;
   logic        Irq;
   logic        txd;

   int tests = 0;
   int fails = 0;
   logic [31:0] r;

   coco_uart_tx #(
      .FIFO_DEPTH (4),
      .DIV_RESET  (16'd10)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .DevAddr (DevAddr),
      .WE      (WE),
      .WD      (WD),
      .RD      (RD),
      .Irq     (Irq),
      .txd     (txd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      DevAddr = a;
      WD      = d;
      WE      = 1'b1;
      @(negedge clk);
      WE = 1'b0;
      WD = 32'd0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      DevAddr = a;
      #1;
      d = RD;
   endtask

   // Expected line level for bit slot idx (0 start, 1..8 data LSB first, 9 stop)
   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return b[idx-1];
   endfunction

   initial begin
      logic [7:0] byt;

      // Reset state
      #12;
      rd(2'd3, r); check("reset status", r, 32'h100);
      rd(2'd1, r); check("reset baud", r, 32'd10);
      rd(2'd0, r); check("reset ctrl", r, 32'd0);
      check("reset txd", txd, 1);
      check("reset irq", Irq, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single frame 0xA5 at 4 clocks per bit
      wr(2'd1, 32'd4);
      rd(2'd1, r); check("baud readback", r, 32'd4);
      wr(2'd0, 32'd1);
      rd(2'd0, r); check("ctrl readback", r, 32'd1);
      wr(2'd2, 32'hA5);
      DevAddr = 2'd3;
      @(posedge clk); #1;
      for (int i = 0; i < 40; i++) begin
         check($sformatf("a5 txd slot %0d", i), txd, frame_bit(8'hA5, i / 4));
         check($sformatf("a5 busy %0d", i), RD[4], 1);
         @(posedge clk); #1;
      end
      rd(2'd3, r); check("a5 done status", r, 32'h120);
      check("a5 idle txd", txd, 1);
      check("a5 irq masked", Irq, 0);
      wr(2'd3, 32'h20);
      rd(2'd3, r); check("pending cleared", r, 32'h100);

      // Overflow with EN=0
      wr(2'd0, 32'd0);
      for (int i = 0; i < 5; i++) wr(2'd2, 32'h10 + i);
      rd(2'd3, r); check("ovf status", r, 32'hC4);
      wr(2'd3, 32'h40);
      rd(2'd3, r); check("ovf cleared", r, 32'h84);

      // Back-to-back frames with interrupt
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      rd(2'd3, r); check("reset2 status", r, 32'h100);
      wr(2'd1, 32'd2);
      wr(2'd2, 32'h55);
      wr(2'd2, 32'h0F);
      wr(2'd0, 32'h9);
      DevAddr = 2'd3;
      @(posedge clk); #1;
      for (int i = 0; i < 40; i++) begin
         byt = (i < 20) ? 8'h55 : 8'h0F;
         check($sformatf("b2b txd %0d", i), txd, frame_bit(byt, (i % 20) / 2));
         check($sformatf("b2b busy %0d", i), RD[4], 1);
         check($sformatf("b2b irq low %0d", i), Irq, 0);
         @(posedge clk); #1;
      end
      check("b2b irq high", Irq, 1);
      rd(2'd3, r); check("b2b status", r, 32'h120);
      wr(2'd3, 32'h20);
      check("b2b irq cleared", Irq, 0);

      // Asynchronous reset mid-DATA
      wr(2'd1, 32'd4);
      wr(2'd0, 32'd1);
      wr(2'd2, 32'h00);
      DevAddr = 2'd3;
      @(posedge clk); #1;
      repeat (12) @(posedge clk);
      #1;
      check("mid data txd low", txd, 0);
      check("mid data busy", RD[4], 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset txd", txd, 1);
      check("async reset irq", Irq, 0);
      rd(2'd3, r); check("async reset status", r, 32'h100);
      rd(2'd0, r); check("async reset ctrl", r, 32'd0);
      rd(2'd1, r); check("async reset baud", r, 32'd10);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("post reset txd", txd, 1);

      // EN cleared mid-frame
      wr(2'd1, 32'd2);
      wr(2'd2, 32'h11);
      wr(2'd2, 32'h22);
      wr(2'd2, 32'h33);
      wr(2'd0, 32'd1);
      @(posedge clk); #1;
      rd(2'd3, r); check("en frame started", r, 32'h12);
      wr(2'd0, 32'd0);
      rd(2'd3, r); check("en cleared still busy", r, 32'h12);
      repeat (25) @(posedge clk);
      #1;
      rd(2'd3, r); check("en cleared done", r, 32'h02);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("en cleared idle txd %0d", i), txd, 1);
         @(posedge clk); #1;
      end
      rd(2'd3, r); check("en cleared count held", r, 32'h02);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
